// File: rtl/fft_8p_pipe.sv
// fft_8p_pipe: 8-point radix-2 DIT FFT built as three registered butterfly stages.
// The pipeline advances on a single global enable: it moves when the output
// register is empty or the consumer takes the frame.
// Optional feature macro: FFT_STAGE_SCALE_EN. When it is defined, every stage
// halves its butterfly outputs (floor), so the result is X/8. When it is not
// defined, all arithmetic wraps modulo 2^DW.
module fft_8p_pipe #(
  parameter int DW    = 16,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*DW-1:0]    xt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*DW-1:0]    xf,
  output logic [CNT_W-1:0]    frame_cnt
);

  typedef logic signed [DW-1:0] cw_t;
  typedef logic signed [DW:0]   xw_t;

  // round(0.70710678 * 2^(DW-1)); for DW=16 this is 23170
  localparam xw_t TW_C = xw_t'($rtoi(0.70710678 * (2.0 ** (DW - 1)) + 0.5));

  function automatic xw_t ext(input cw_t v);
    return {v[DW-1], v};
  endfunction

  // Butterfly sums are formed at DW+2 bits; the stage output either wraps to DW
  // bits or, with scaling enabled, takes bits [DW:1] (arithmetic shift right by 1).
  function automatic cw_t fold(input logic [DW+1:0] v);
`ifdef FFT_STAGE_SCALE_EN
    return v[DW:1];
`else
    return v[DW-1:0];
`endif
  endfunction

  function automatic cw_t bf_add(input xw_t a, input xw_t b);
    return fold({a[DW], a} + {b[DW], b});
  endfunction

  function automatic cw_t bf_sub(input xw_t a, input xw_t b);
    return fold({a[DW], a} - {b[DW], b});
  endfunction

  // Multiply by C, then shift right by DW-1 (floor). The sign-extended
  // operands make the low 2*DW+2 product bits exact.
  function automatic xw_t cmul(input xw_t s);
    logic [2*DW+1:0] p;
    p = {{(DW+1){s[DW]}}, s} * {{(DW+1){TW_C[DW]}}, TW_C};
    return p[2*DW-1:DW-1];
  endfunction

  logic enable;
  logic s1_valid, s2_valid, s3_valid;
  cw_t  x_re [8], x_im [8];
  cw_t  n1_re[8], n1_im[8], s1_re[8], s1_im[8];
  cw_t  n2_re[8], n2_im[8], s2_re[8], s2_im[8];
  cw_t  n3_re[8], n3_im[8], s3_re[8], s3_im[8];
  xw_t  t_re [4], t_im [4];

  assign enable    = !s3_valid || out_ready;
  assign in_ready  = enable;
  assign out_valid = s3_valid;

  // S1: unpack the samples and form the W0 butterflies on pairs (0,4),(2,6),(1,5),(3,7)
  always_comb begin
    int unsigned lo;
    for (int unsigned k = 0; k < 8; k++) begin
      x_re[k] = xt[2*DW*k+DW +: DW];
      x_im[k] = xt[2*DW*k    +: DW];
    end
    for (int unsigned b = 0; b < 4; b++) begin
      lo = 2 * (b % 2) + b / 2;
      n1_re[2*b]   = bf_add(ext(x_re[lo]), ext(x_re[lo+4]));
      n1_im[2*b]   = bf_add(ext(x_im[lo]), ext(x_im[lo+4]));
      n1_re[2*b+1] = bf_sub(ext(x_re[lo]), ext(x_re[lo+4]));
      n1_im[2*b+1] = bf_sub(ext(x_im[lo]), ext(x_im[lo+4]));
    end
  end

  // S2: 4-point combines for the even (0..3) and odd (4..7) halves, using W0 and W2 = -j
  always_comb begin
    for (int unsigned g = 0; g < 8; g += 4) begin
      n2_re[g]   = bf_add(ext(s1_re[g]),   ext(s1_re[g+2]));
      n2_im[g]   = bf_add(ext(s1_im[g]),   ext(s1_im[g+2]));
      n2_re[g+2] = bf_sub(ext(s1_re[g]),   ext(s1_re[g+2]));
      n2_im[g+2] = bf_sub(ext(s1_im[g]),   ext(s1_im[g+2]));
      n2_re[g+1] = bf_add(ext(s1_re[g+1]), ext(s1_im[g+3]));
      n2_im[g+1] = bf_sub(ext(s1_im[g+1]), ext(s1_re[g+3]));
      n2_re[g+3] = bf_sub(ext(s1_re[g+1]), ext(s1_im[g+3]));
      n2_im[g+3] = bf_add(ext(s1_im[g+1]), ext(s1_re[g+3]));
    end
  end

  // S3: rotate the odd half by W0..W3 and combine it with the even half into X[0..7]
  always_comb begin
    t_re[0] = ext(s2_re[4]);
    t_im[0] = ext(s2_im[4]);
    t_re[1] = cmul(ext(s2_re[5]) + ext(s2_im[5]));
    t_im[1] = cmul(ext(s2_im[5]) - ext(s2_re[5]));
    t_re[2] = ext(s2_im[6]);
    t_im[2] = -ext(s2_re[6]);
    t_re[3] = cmul(ext(s2_im[7]) - ext(s2_re[7]));
    t_im[3] = cmul(-ext(s2_re[7]) - ext(s2_im[7]));
    for (int unsigned k = 0; k < 4; k++) begin
      n3_re[k]   = bf_add(ext(s2_re[k]), t_re[k]);
      n3_im[k]   = bf_add(ext(s2_im[k]), t_im[k]);
      n3_re[k+4] = bf_sub(ext(s2_re[k]), t_re[k]);
      n3_im[k+4] = bf_sub(ext(s2_im[k]), t_im[k]);
    end
  end

  // Stage registers: every stage moves together on the global enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      for (int unsigned k = 0; k < 8; k++) begin
        s1_re[k] <= '0;  s1_im[k] <= '0;
        s2_re[k] <= '0;  s2_im[k] <= '0;
        s3_re[k] <= '0;  s3_im[k] <= '0;
      end
    end else if (enable) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      for (int unsigned k = 0; k < 8; k++) begin
        s1_re[k] <= n1_re[k];  s1_im[k] <= n1_im[k];
        s2_re[k] <= n2_re[k];  s2_im[k] <= n2_im[k];
        s3_re[k] <= n3_re[k];  s3_im[k] <= n3_im[k];
      end
    end
  end

  // Delivered-frame counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_cnt <= '0;
    else if (s3_valid && out_ready)
      frame_cnt <= frame_cnt + 1'b1;
  end

  // Output packing; xf is forced to zero whenever no frame is valid
  always_comb begin
    xf = '0;
    if (s3_valid) begin
      for (int unsigned k = 0; k < 8; k++) begin
        xf[2*DW*k+DW +: DW] = s3_re[k];
        xf[2*DW*k    +: DW] = s3_im[k];
      end
    end
  end

endmodule

// File: tb/tb_fft_8p_pipe.sv
// tb_fft_8p_pipe: directed, scoreboard-based bench for fft_8p_pipe (DW=16, CNT_W=4).
// Expected frames are hand-derived constants pushed when a frame is accepted
// and popped by the output monitor.
module tb_fft_8p_pipe;

  localparam int DW    = 16;
  localparam int CNT_W = 4;

  typedef logic [16*DW-1:0] frame_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  frame_t           xt = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  frame_t           xf;
  logic [CNT_W-1:0] frame_cnt;

  fft_8p_pipe #(.DW(DW), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .xt        (xt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xf        (xf),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  frame_t           q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  frame_t           held = '0;
  bit               held_v = 1'b0;
  frame_t           mon_e;
  frame_t           vin [8];
  frame_t           vexp[8];
  int               vr[8];
  int               vi[8];

  task automatic chk(input string tag, input frame_t obs, input frame_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic frame_t pk();
    frame_t f;
    int     r;
    int     i;
    f = '0;
    for (int k = 0; k < 8; k++) begin
      r = vr[k];
      i = vi[k];
      f[2*DW*k+DW +: DW] = r[DW-1:0];
      f[2*DW*k    +: DW] = i[DW-1:0];
    end
    return f;
  endfunction

  // Offer a frame until it is accepted (bounded), then push its expected result
  task automatic send(input frame_t f, input frame_t e);
    int unsigned n;
    bit          acc;
    n   = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    xt       = f;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (acc) q.push_back(e);
    else chk("accept_timeout", frame_t'(in_ready), frame_t'(1));
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", frame_t'(q.size()), frame_t'(0));
    @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard compare on each handshake, idle-zero and stall-hold checks
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_frame", frame_t'(out_valid), frame_t'(0));
        end else begin
          mon_e = q.pop_front();
          chk("xf", xf, mon_e);
          chk("frame_cnt_run", frame_t'(frame_cnt), frame_t'(exp_cnt));
          exp_cnt = exp_cnt + 1'b1;
        end
      end else if (!out_valid) begin
        chk("xf_idle", xf, frame_t'(0));
      end
      if (out_valid && !out_ready) begin
        if (held_v) chk("xf_stall", xf, held);
        held   = xf;
        held_v = 1'b1;
      end else begin
        held_v = 1'b0;
      end
    end
  end

  initial begin
    // 0: impulse x0=(1,0) -> all (1,0)
    vr = '{1, 0, 0, 0, 0, 0, 0, 0};  vi = '{default: 0};  vin[0] = pk();
    vr = '{default: 1};                                    vexp[0] = pk();
    // 1: DC (1000,0) -> X0=(8000,0)
    vr = '{default: 1000};                                 vin[1] = pk();
    vr = '{8000, 0, 0, 0, 0, 0, 0, 0};                     vexp[1] = pk();
    // 2: alternating +-1000 -> X4=(8000,0)
    vr = '{1000, -1000, 1000, -1000, 1000, -1000, 1000, -1000}; vin[2] = pk();
    vr = '{0, 0, 0, 0, 8000, 0, 0, 0};                     vexp[2] = pk();
    // 3: x1=(1000,0) -> 1000*W8^k with floor rounding on the diagonals
    vr = '{0, 1000, 0, 0, 0, 0, 0, 0};                     vin[3] = pk();
    vr = '{1000, 707, 0, -708, -1000, -707, 0, 708};
    vi = '{0, -708, -1000, -708, 0, 708, 1000, 708};       vexp[3] = pk();
    // 4: x2=(1000,0) -> 1000*(-j)^k
    vr = '{0, 0, 1000, 0, 0, 0, 0, 0};  vi = '{default: 0}; vin[4] = pk();
    vr = '{1000, 0, -1000, 0, 1000, 0, -1000, 0};
    vi = '{0, -1000, 0, 1000, 0, -1000, 0, 1000};          vexp[4] = pk();
    // 5: imaginary impulse x0=(0,500) -> all (0,500)
    vr = '{default: 0};  vi = '{500, 0, 0, 0, 0, 0, 0, 0}; vin[5] = pk();
    vi = '{default: 500};                                  vexp[5] = pk();
    // 6: overflow, all (32767,0) -> X0 wraps to (-8,0)
    vr = '{default: 32767};  vi = '{default: 0};           vin[6] = pk();
    vr = '{-8, 0, 0, 0, 0, 0, 0, 0};                       vexp[6] = pk();
    // 7: x4=(1000,0) -> 1000*(-1)^k
    vr = '{0, 0, 0, 0, 1000, 0, 0, 0};                     vin[7] = pk();
    vr = '{1000, -1000, 1000, -1000, 1000, -1000, 1000, -1000}; vexp[7] = pk();

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", frame_t'(out_valid), frame_t'(0));
    chk("rst_xf",        xf,                  frame_t'(0));
    chk("rst_frame_cnt", frame_t'(frame_cnt), frame_t'(0));
    chk("rst_in_ready",  frame_t'(in_ready),  frame_t'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Impulse with exact latency check
    send(vin[0], vexp[0]);
    @(negedge clk); chk("lat_c1", frame_t'(out_valid), frame_t'(0));
    @(negedge clk); chk("lat_c2", frame_t'(out_valid), frame_t'(0));
    @(negedge clk); chk("lat_c3", frame_t'(out_valid), frame_t'(1));
    drain();
    chk("frame_cnt_impulse", frame_t'(frame_cnt), frame_t'(1));

    // Remaining directed vectors separated by bubbles
    for (int i = 1; i < 8; i++) begin
      send(vin[i], vexp[i]);
      @(posedge clk);
      #1;
    end
    drain();
    chk("frame_cnt_directed", frame_t'(frame_cnt), frame_t'(8));

    // Back-to-back burst of 10 frames: full throughput and counter wrap (18 -> 2)
    for (int i = 0; i < 10; i++) send(vin[i % 8], vexp[i % 8]);
    drain();
    chk("frame_cnt_wrap", frame_t'(frame_cnt), frame_t'(2));

    // Reset with two frames in flight
    send(vin[1], vexp[1]);
    send(vin[2], vexp[2]);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", frame_t'(out_valid), frame_t'(0));
    chk("midrst_xf",        xf,                  frame_t'(0));
    chk("midrst_frame_cnt", frame_t'(frame_cnt), frame_t'(0));
    chk("midrst_in_ready",  frame_t'(in_ready),  frame_t'(1));
    q.delete();
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale", frame_t'(out_valid), frame_t'(0));
    end
    @(posedge clk);
    #1;

    // Backpressure: 5 back-to-back frames, consumer stalls for 4 cycles mid-stream
    fork
      begin
        for (int i = 1; i < 6; i++) send(vin[i], vexp[i]);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall_in_ready",  frame_t'(in_ready),  frame_t'(0));
          chk("stall_out_valid", frame_t'(out_valid), frame_t'(1));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("frame_cnt_bp", frame_t'(frame_cnt), frame_t'(5));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
